// File: rtl/bg_index_fetch_if.sv
// Pixel/scroll inputs, background ROM port and palette-index output of bg_index_fetch.
// master = scan/ROM side driving the block, slave = bg_index_fetch itself.
interface bg_index_fetch_if #(
   parameter int IDX_W  = 4,
   parameter int ADDR_W = 18
);
   logic              frame_start;
   logic [9:0]        scroll_x;
   logic              pix_valid;
   logic [9:0]        DrawX;
   logic [9:0]        DrawY;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic [IDX_W-1:0]  mem_q;
   logic [IDX_W-1:0]  idx_out;
   logic              idx_valid;
   logic [9:0]        scroll_act;

   modport master (
      output frame_start, scroll_x, pix_valid, DrawX, DrawY, mem_q,
      input  mem_addr, mem_rd, idx_out, idx_valid, scroll_act
   );

   modport slave (
      input  frame_start, scroll_x, pix_valid, DrawX, DrawY, mem_q,
      output mem_addr, mem_rd, idx_out, idx_valid, scroll_act
   );
endinterface

// File: rtl/bg_index_fetch.sv
// Background index fetch: scan position + frame-latched scroll -> half-res ROM address -> palette index, 3-cycle latency.
// Define BG_WRAP_EN for a horizontally tiling background (scroll and x wrap mod BG_WIDTH) instead of clamping the scroll.
module bg_index_fetch #(
   parameter int BG_WIDTH  = 1024,
   parameter int BG_HEIGHT = 240,
   parameter int IDX_W     = 4,
   parameter int ADDR_W    = 18,
   parameter int VIS_W     = 320
) (
   input  logic Clk,
   input  logic Reset,
   bg_index_fetch_if.slave bus
);

   localparam int         XW          = $clog2(BG_WIDTH);
   localparam logic [9:0] SCROLL_MAX  = 10'(BG_WIDTH - VIS_W);
   localparam logic [9:0] SCROLL_MASK = 10'(BG_WIDTH - 1);
   localparam logic [10:0] SX_MASK    = 11'(BG_WIDTH - 1);
   localparam logic [9:0] ROW_LIM     = 10'(BG_HEIGHT);

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   state_t            r_state;
   logic [9:0]        r_scroll_act;
   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_mem_rd;
   logic              r_v1, r_f1;
   logic              r_v2, r_f2;
   logic [IDX_W-1:0]  r_idx_out;
   logic              r_idx_valid;

   logic [8:0]        w_sy;
   logic [10:0]       w_sx_sum;
   logic [10:0]       w_sx;
   logic [ADDR_W-1:0] w_addr;
   logic              w_row_oob;
   logic              w_go;
   logic              w_rd;
   logic              w_force;

   // Scroll value latched at a frame boundary: clamped so the visible window stays inside the stored image, or wrapped when tiling.
   function automatic logic [9:0] f_scroll_next(input logic [9:0] req);
`ifdef BG_WRAP_EN
      return req & SCROLL_MASK;
`else
      return (req > SCROLL_MAX) ? SCROLL_MAX : req;
`endif
   endfunction

   always_comb begin
      w_sy     = 9'(bus.DrawY >> 1);
      w_sx_sum = 11'({1'b0, bus.DrawX} >> 1) + {1'b0, r_scroll_act};
`ifdef BG_WRAP_EN
      w_sx     = w_sx_sum & SX_MASK;
`else
      w_sx     = w_sx_sum;
`endif
      // Row stride is a power of two, so the row goes above the x bits without a multiplier.
      w_addr    = (ADDR_W'(w_sy) << XW) | ADDR_W'(w_sx);
      w_row_oob = ({1'b0, w_sy} >= ROW_LIM);
      w_go      = bus.pix_valid & (r_state == S_ACTIVE);
      w_rd      = w_go & ~w_row_oob;
      w_force   = w_go & w_row_oob;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state      <= S_IDLE;
         r_scroll_act <= '0;
         r_mem_addr   <= '0;
         r_mem_rd     <= 1'b0;
         r_v1         <= 1'b0;
         r_f1         <= 1'b0;
         r_v2         <= 1'b0;
         r_f2         <= 1'b0;
         r_idx_out    <= '0;
         r_idx_valid  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE:   if (bus.frame_start) r_state <= S_ACTIVE;
            S_ACTIVE: r_state <= S_ACTIVE;
            default:  r_state <= S_IDLE;
         endcase

         if (bus.frame_start)
            r_scroll_act <= f_scroll_next(bus.scroll_x);

         // p0: address and read strobe
         r_mem_addr <= w_addr;
         r_mem_rd   <= w_rd;
         r_v1       <= w_rd;
         r_f1       <= w_force;

         // p1: ROM registers its data
         r_v2 <= r_v1;
         r_f2 <= r_f1;

         // p2: index out; bubbles keep the previous index, off-image rows read as index 0
         if (r_f2)
            r_idx_out <= '0;
         else if (r_v2)
            r_idx_out <= bus.mem_q;
         r_idx_valid <= r_v2 | r_f2;
      end
   end

   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_rd     = r_mem_rd;
   assign bus.idx_out    = r_idx_out;
   assign bus.idx_valid  = r_idx_valid;
   assign bus.scroll_act = r_scroll_act;

endmodule

// File: tb/tb_bg_index_fetch.sv
// Directed bench for bg_index_fetch: reset, scroll shadowing/clamp, pipeline latency, bubbles, off-image rows, mid-frame reset.
module tb_bg_index_fetch;

   localparam int IDX_W  = 4;
   localparam int ADDR_W = 18;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   bg_index_fetch_if #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) bus ();

   bg_index_fetch #(
      .BG_WIDTH(1024), .BG_HEIGHT(240), .IDX_W(IDX_W), .ADDR_W(ADDR_W), .VIS_W(320)
   ) dut (
      .Clk(clk), .Reset(rst), .bus(bus)
   );

   // ROM contents: low address nibble xor 3
   function automatic logic [3:0] rom_q(input logic [ADDR_W-1:0] a);
      return a[3:0] ^ 4'h3;
   endfunction

   always @(posedge clk)
      if (bus.mem_rd) bus.mem_q <= rom_q(bus.mem_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pix(input logic v, input logic [9:0] x, input logic [9:0] y);
      bus.pix_valid = v;
      bus.DrawX     = x;
      bus.DrawY     = y;
   endtask

   task automatic new_frame(input logic [9:0] sx);
      bus.scroll_x    = sx;
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.frame_start = 1'b0;
      bus.scroll_x    = '0;
      pix(1'b0, 10'd0, 10'd0);
      tick();
      tick();
      chk("rst_addr",   32'(bus.mem_addr),   32'd0);
      chk("rst_rd",     32'(bus.mem_rd),     32'd0);
      chk("rst_idx",    32'(bus.idx_out),    32'd0);
      chk("rst_vld",    32'(bus.idx_valid),  32'd0);
      chk("rst_scroll", 32'(bus.scroll_act), 32'd0);
      rst = 1'b0;
      tick();

      // no reads before the first frame_start
      pix(1'b1, 10'd10, 10'd20);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("idle_rd",  32'(bus.mem_rd),    32'd0);
         chk("idle_vld", 32'(bus.idx_valid), 32'd0);
      end
      chk("idle_addr", 32'(bus.mem_addr), 32'd10245);

      // basic fetch and 3-cycle latency
      pix(1'b0, 10'd10, 10'd20);
      new_frame(10'd100);
      chk("t1_scroll", 32'(bus.scroll_act), 32'd100);
      pix(1'b1, 10'd10, 10'd20);
      tick();
      chk("t1_addr", 32'(bus.mem_addr),  32'd10345);
      chk("t1_rd",   32'(bus.mem_rd),    32'd1);
      chk("t1_vld1", 32'(bus.idx_valid), 32'd0);
      pix(1'b0, 10'd10, 10'd20);
      tick();
      chk("t1_vld2", 32'(bus.idx_valid), 32'd0);
      tick();
      chk("t1_vld3", 32'(bus.idx_valid), 32'd1);
      chk("t1_idx",  32'(bus.idx_out),   32'hA);
      tick();
      chk("t1_vld4", 32'(bus.idx_valid), 32'd0);
      chk("t1_hold", 32'(bus.idx_out),   32'hA);

      // scroll only changes at a frame boundary
      bus.scroll_x = 10'd200;
      pix(1'b1, 10'd0, 10'd0);
      tick();
      chk("t2_mid_addr",   32'(bus.mem_addr),   32'd100);
      chk("t2_mid_scroll", 32'(bus.scroll_act), 32'd100);
      pix(1'b0, 10'd0, 10'd0);
      new_frame(10'd200);
      chk("t2_scroll", 32'(bus.scroll_act), 32'd200);
      pix(1'b1, 10'd0, 10'd0);
      tick();
      chk("t2_addr", 32'(bus.mem_addr), 32'd200);
      bus.scroll_x    = 10'd300;
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      chk("t2_same_addr",   32'(bus.mem_addr),   32'd200);
      chk("t2_same_scroll", 32'(bus.scroll_act), 32'd300);
      pix(1'b0, 10'd0, 10'd0);

      // clamp (or wrap) at the bottom-right corner
      new_frame(10'd900);
      pix(1'b1, 10'd639, 10'd479);
      tick();
`ifdef BG_WRAP_EN
      chk("t3_scroll", 32'(bus.scroll_act), 32'd900);
      chk("t3_addr",   32'(bus.mem_addr),   32'd244931);
`else
      chk("t3_scroll", 32'(bus.scroll_act), 32'd704);
      chk("t3_addr",   32'(bus.mem_addr),   32'd245759);
`endif
      chk("t3_rd", 32'(bus.mem_rd), 32'd1);
      // row 240 is beyond the stored image
      pix(1'b1, 10'd0, 10'd480);
      tick();
`ifdef BG_WRAP_EN
      chk("oob_addr", 32'(bus.mem_addr), 32'd246660);
`else
      chk("oob_addr", 32'(bus.mem_addr), 32'd246464);
`endif
      chk("oob_rd", 32'(bus.mem_rd), 32'd0);
      pix(1'b0, 10'd0, 10'd0);
      tick();
`ifdef BG_WRAP_EN
      chk("t3_idx", 32'(bus.idx_out), 32'h0);
`else
      chk("t3_idx", 32'(bus.idx_out), 32'hC);
`endif
      chk("t3_vld", 32'(bus.idx_valid), 32'd1);
      tick();
      chk("oob_vld", 32'(bus.idx_valid), 32'd1);
      chk("oob_idx", 32'(bus.idx_out),   32'd0);
      tick();
      chk("oob_after", 32'(bus.idx_valid), 32'd0);

      // 8-pixel stream with a bubble at the 4th slot
      new_frame(10'd0);
      for (int k = 0; k < 10; k++) begin
         if (k < 8) pix(k != 3, 10'(2 * k), 10'd0);
         else       pix(1'b0, 10'd0, 10'd0);
         tick();
         if (k < 8) begin
            chk("s_rd",   32'(bus.mem_rd),   32'(k != 3));
            chk("s_addr", 32'(bus.mem_addr), 32'(k));
         end
         if (k >= 2) begin
            chk("s_vld", 32'(bus.idx_valid), 32'((k - 2) != 3));
            chk("s_idx", 32'(bus.idx_out),
                32'(rom_q(ADDR_W'((k - 2) == 3 ? 2 : (k - 2)))));
         end
      end

      // asynchronous reset with three pixels in flight
      pix(1'b1, 10'd0, 10'd2);
      tick();
      pix(1'b1, 10'd2, 10'd2);
      tick();
      pix(1'b1, 10'd4, 10'd2);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_vld",    32'(bus.idx_valid),  32'd0);
      chk("ar_rd",     32'(bus.mem_rd),     32'd0);
      chk("ar_addr",   32'(bus.mem_addr),   32'd0);
      chk("ar_idx",    32'(bus.idx_out),    32'd0);
      chk("ar_scroll", 32'(bus.scroll_act), 32'd0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("ar_post_vld", 32'(bus.idx_valid), 32'd0);
         chk("ar_post_rd",  32'(bus.mem_rd),    32'd0);
      end
      pix(1'b0, 10'd0, 10'd0);
      new_frame(10'd0);
      pix(1'b1, 10'd6, 10'd2);
      tick();
      chk("ar_resume_addr", 32'(bus.mem_addr), 32'd1027);
      pix(1'b0, 10'd0, 10'd0);
      tick();
      tick();
      chk("ar_resume_vld", 32'(bus.idx_valid), 32'd1);
      chk("ar_resume_idx", 32'(bus.idx_out),   32'(rom_q(ADDR_W'(1027))));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/bg_index_fetch.md
Name: bg_index_fetch

Overview:
- Upstream stage of the area/forest palette lookups.
- Takes the VGA scan position and the camera scroll, and addresses the on-chip background index ROM, which is stored at half resolution (320x240 visible).
- Delivers a pipelined palette index with a valid flag, which the palette stage converts to RGB.
- The horizontal scroll is double-buffered so it only changes at frame boundaries.

Parameters:
- BG_WIDTH, 1024: stored background width in pixels. Must be a power of two; the row stride equals this value.
- BG_HEIGHT, 240: stored background height in pixels.
- IDX_W, 4: palette index width. Use 4 for forest, 3 for area.
- ADDR_W, 18: ROM address width. Must satisfy 2^ADDR_W >= BG_WIDTH*BG_HEIGHT.
- VIS_W, 320: visible stored-pixel width, i.e. 640 screen pixels / 2.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  single-cycle pulse at the start of vertical blanking.
- scroll_x  in  10  requested camera x offset, in stored pixels.
- pix_valid  in  1  VGA display-enable for the current DrawX/DrawY.
- DrawX  in  10  screen x, 0..639.
- DrawY  in  10  screen y, 0..479.
- mem_addr  out  ADDR_W  ROM read address.
- mem_rd  out  1  ROM read enable.
- mem_q  in  IDX_W  ROM data. Synchronous ROM: data appears the cycle after the address is presented.
- idx_out  out  IDX_W  palette index to the palette stage.
- idx_valid  out  1  idx_out is valid.
- scroll_act  out  10  scroll value currently in use.

Behaviour:
- Reset values: mem_addr=0, mem_rd=0, idx_out=0, idx_valid=0, scroll_act=0. State = IDLE.
- State machine, two states:
  - IDLE: no reads issued; mem_rd=0 and idx_valid=0 regardless of pix_valid. Moves to ACTIVE on frame_start.
  - ACTIVE: normal pipelined operation. Stays in ACTIVE until Reset.
- Scroll shadow:
  - On frame_start (in either state), scroll_act <= min(scroll_x, BG_WIDTH-VIS_W). With defaults the clamp value is 704.
  - At all other times scroll_act holds; scroll_x changes mid-frame have no effect.
  - When frame_start and pix_valid are high in the same cycle, the old scroll_act is used for that pixel.
- Address computation:
  - sx = (DrawX>>1) + scroll_act, evaluated 11 bits wide.
  - sy = DrawY>>1.
  - addr = sy*BG_WIDTH + sx, implemented as a shift and OR (no multiplier), truncated to ADDR_W.
- Pipeline, inputs sampled in cycle n:
  - Edge n->n+1: mem_addr <= addr; mem_rd <= pix_valid & ACTIVE; v1 <= the same value.
  - Edge n+1->n+2: ROM registers its output; v2 <= v1.
  - Edge n+2->n+3: idx_out <= mem_q; idx_valid <= v2.
  - Total latency is 3 cycles, fixed. The caller delays hsync/vsync by 3 cycles to match.
  - Back-to-back pixels are accepted every cycle; there is no stall.
- Invalid pixels:
  - When pix_valid=0, mem_addr still updates, but mem_rd=0 and the bubble propagates.
  - For a bubble, idx_valid=0 and idx_out holds its previous value.
- Out-of-range rows: if sy >= BG_HEIGHT, the pixel is forced to index 0 (transparent/background colour) with idx_valid=1, and mem_rd=0.
- Reset mid-frame:
  - All in-flight pipeline entries are dropped and outputs return to reset values immediately (asynchronous).
  - The block re-enters IDLE and produces no valid output until the next frame_start.

Optional Feature:
- Macro BG_WRAP_EN.
- When defined:
  - No clamp: scroll_act <= scroll_x mod BG_WIDTH.
  - sx = ((DrawX>>1) + scroll_act) mod BG_WIDTH, giving a horizontally tiling background.
- When undefined: the clamp rule above applies, and sx never exceeds BG_WIDTH-1 by construction.

Test Plan:
1. Reset, frame_start, scroll_x=100; pix_valid=1, DrawX=10, DrawY=20 -> next cycle mem_addr=10*1024+105=10345 and mem_rd=1. With mem_q=4'hA, idx_out=A and idx_valid=1 exactly 3 cycles after input.
2. ACTIVE with scroll_act=100; change scroll_x to 200 mid-frame, pixel DrawX=0, DrawY=0 -> mem_addr=100. After the next frame_start the same pixel gives mem_addr=200.
3. frame_start with scroll_x=900 -> scroll_act=704; DrawX=639, DrawY=479 -> mem_addr=239*1024+1023=245759. With BG_WRAP_EN: scroll_act=900, mem_addr=239*1024+195=244931.
4. Stream of 8 consecutive valid pixels with a pix_valid=0 gap at the 4th -> 7 valid outputs in order, idx_valid low for exactly one cycle at position 4 (3 cycles delayed), and mem_rd low for that slot.
5. pix_valid=1 before any frame_start after reset -> mem_rd=0 and idx_valid stays 0 indefinitely.
6. Assert Reset while 3 pixels are in flight -> idx_valid=0 immediately and never rises for those pixels. After release, no valid output until frame_start.
